// File: rtl/chien_search_sched.sv
// Chien root search sequencer for a T-error BCH locator over GF(2^13).
// Optional CHIEN_EARLY_STOP_EN ends the search once every expected root has been found.

module chien_lane #(
    parameter int I = 0
) (
    input  logic [12:0] a,
    output logic [12:0] y
);
    // Constant multiply by alpha^I: I shifts modulo x^13+x^4+x^3+x+1.
    function automatic logic [12:0] mul_alpha_pow(input logic [12:0] v, input int n);
        logic [12:0] r;
        r = v;
        for (int k = 0; k < n; k++)
            r = {r[11:0], 1'b0} ^ (r[12] ? 13'h001B : 13'h0000);
        return r;
    endfunction

    assign y = mul_alpha_pow(a, I);
endmodule

module chien_search_sched #(
    parameter  int T  = 4,
    parameter  int N  = 8191,
    localparam int CW = $clog2(T + 1) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [13*(T+1)-1:0] lambda_in,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [12:0]         err_pos,
    output logic                done,
    output logic                fail,
    output logic [CW-1:0]       err_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEARCH, S_DRAIN, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [T:0][12:0]   lane_q, lane_d, lane_nxt;
    logic [12:0]        j_q, j_d;
    logic [12:0]        pos_q, pos_d;
    logic [CW-1:0]      deg_q, deg_d, deg_c;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ov_q, ov_d;
    logic               fail_q, fail_d;
    logic [12:0]        sum;
    logic               slot_free;

    for (genvar g = 0; g <= T; g++) begin : g_lane
        chien_lane #(.I(g)) u_lane (.a(lane_q[g]), .y(lane_nxt[g]));
    end

    always_comb begin
        sum   = '0;
        deg_c = '0;
        for (int i = 0; i <= T; i++) sum = sum ^ lane_q[i];
        for (int i = 1; i <= T; i++)
            if (lane_q[i] != '0) deg_c = CW'(i);
    end

    assign slot_free = !ov_q || out_ready;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        j_d     = j_q;
        pos_d   = pos_q;
        deg_d   = deg_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        ov_d    = ov_q && !out_ready;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_LOAD;
                lane_d  = lambda_in;
                cnt_d   = '0;
                fail_d  = 1'b0;
            end
            S_LOAD: begin
                deg_d = deg_c;
                j_d   = '0;
                cnt_d = '0;
                // Zero constant term cannot be a valid locator: skip the search.
                if (lane_q[0] == '0) begin
                    fail_d  = 1'b1;
                    state_d = S_FIN;
                end
`ifdef CHIEN_EARLY_STOP_EN
                else if (deg_c == '0) state_d = S_DRAIN;
`endif
                else state_d = S_SEARCH;
            end
            S_SEARCH: if (slot_free) begin
                lane_d = lane_nxt;
                j_d    = j_q + 13'd1;
                if (sum == '0) begin
                    pos_d = (j_q == '0) ? 13'd0 : 13'd8191 - j_q;
                    ov_d  = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
                if (j_q == 13'(N - 1)) state_d = S_DRAIN;
`ifdef CHIEN_EARLY_STOP_EN
                else if (sum == '0 && deg_q != '0 && cnt_d == deg_q) state_d = S_DRAIN;
`endif
            end
            S_DRAIN: if (slot_free) begin
                state_d = S_FIN;
                fail_d  = (cnt_q != deg_q);
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            j_q     <= '0;
            pos_q   <= '0;
            deg_q   <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            j_q     <= j_d;
            pos_q   <= pos_d;
            deg_q   <= deg_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            fail_q  <= fail_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign out_valid = ov_q;
    assign err_pos   = pos_q;
    assign err_cnt   = cnt_q;
    assign fail      = fail_q;
endmodule

// File: doc/chien_search_sched.md
# chien_search_sched

- Sequences the Chien root search of the BCH error-locator polynomial over GF(2^13).
- Holds one locator register per coefficient. Each lane is advanced every search step by its own constant multiplier (multiply by alpha^i for lane i).
- Tests the lane sum for zero and streams error positions to the corrector through a one-entry ready/valid output buffer.
- Sits between the Euclidean key-equation solver and the error-correction stage.

## Interface
- T, 4, error-correcting capability; locator degree ≤ T, T+1 lanes.
- N, 8191, positions searched (j = 0..N-1); 1 ≤ N ≤ 8191.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin search; sampled only in IDLE.
- lambda_in  in  13*(T+1)  locator coefficients; lane i at bits [13i+12:13i]; sampled on accepted start.
- busy  out  1  high from accepted start until done pulse (inclusive).
- out_valid  out  1  err_pos valid.
- out_ready  in  1  consumer accepts err_pos.
- err_pos  out  13  error position = (8191 − j) mod 8191.
- done  out  1  one-cycle completion pulse.
- fail  out  1  valid with done; held until next accepted start.
- err_cnt  out  $clog2(T+1)+1  roots found; held until next accepted start.

## Operation
- Field: GF(2^13), primitive polynomial x^13+x^4+x^3+x+1, bit k = coefficient of alpha^k.
- FSM states: IDLE, LOAD, SEARCH, DRAIN, FIN.
- IDLE → LOAD on start.
  - LOAD registers lane_i = lambda_i.
  - LOAD computes deg = highest i with lambda_i ≠ 0 (0 if only lambda_0 nonzero).
  - LOAD clears j and err_cnt.
- Fast fail: if lambda_0 == 0 at LOAD, go LOAD → FIN with fail=1, no search.
- SEARCH step (one position j):
  - A step executes only when the output slot is free: out_valid==0 or out_ready==1.
  - sum = XOR of all lanes = Lambda(alpha^j).
  - If sum == 0: load err_pos, set out_valid, increment err_cnt (saturate at 2^width − 1).
  - Every step: lane_i <= lane_i * alpha^i; lane 0 is unchanged.
  - Every step: j <= j+1.
- SEARCH → DRAIN after the step with j == N−1. DRAIN → FIN once out_valid==0 or out_ready==1.
- FIN: assert done for one cycle; fail = (err_cnt != deg); go to IDLE.
- Output slot: out_valid clears on out_ready without a new root. A simultaneous accept and new root reloads the slot with no bubble.
- start outside IDLE is ignored. lambda_in is don't-care outside the accept cycle.
- rst in any state: return to IDLE, discard the search, drive all outputs to reset values.

## Timing
- Reset values: busy=0, out_valid=0, err_pos=0, done=0, fail=0, err_cnt=0.
- Cycle 0: start accepted. Cycle 1: LOAD, busy=1. Cycle 2: first SEARCH step (j=0).
- A root at step j gives out_valid high the next cycle.
- Without backpressure: j = N−1 at cycle N+1; done at cycle N+3 (DRAIN then FIN).
- Each cycle that out_valid=1 and out_ready=0 while a step is pending stalls the search by one cycle. Lanes and j hold.
- Positions are emitted in ascending j order.

## Configuration
- CHIEN_EARLY_STOP_EN defined:
  - When err_cnt reaches deg with deg > 0, SEARCH → DRAIN immediately after that step.
  - deg == 0 goes LOAD → DRAIN directly, with fail=0 and err_cnt=0.
- Not defined: all N positions are always searched; latency is data-independent.

## Test plan
- lambda = {1,0,0,0,0}, N=8191:
  - No out_valid.
  - done with fail=0, err_cnt=0.
  - Without macro: done at cycle 8194. With macro: done at cycle 3.
- lambda_0=1, lambda_1=13'h0002 (error at position 1):
  - One output, err_pos=1, at j=8190.
  - fail=0, err_cnt=1.
- lambda_0=1, lambda_1=13'h0003, lambda_2=13'h0002:
  - err_pos=0, then err_pos=1.
  - err_cnt=2, fail=0.
  - Repeat with out_ready low for 5 cycles after the first output: the second output and done are each 5 cycles later.
- lambda_0=0, lambda_1=1:
  - done at cycle 2, fail=1, err_cnt=0, no output.
- Assert rst at cycle 100 of a search:
  - Next cycle all outputs are at reset values.
  - A start two cycles later runs a full, correct search.
- Degree mismatch: lambda_0=1, lambda_2=1 (x^2+1 = (x+1)^2, repeated root):
  - One output, err_pos=0.
  - err_cnt=1, fail=1.
